// File: rtl/seq_alu_if.sv
// seq_alu_if: request/response bundle between the control unit and seq_alu.
// The master (control unit) drives start/opcode/operands and watches busy/done.
interface seq_alu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 16
);
    logic                  start;
    logic [SEL_WIDTH-1:0]  ALU_Sel;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] ZHigh;
    logic [DATA_WIDTH-1:0] ZLow;
    logic                  carry;
    logic                  div_zero;

    modport master (
        output start, ALU_Sel, A, B,
        input  busy, done, ZHigh, ZLow, carry, div_zero
    );

    modport slave (
        input  start, ALU_Sel, A, B,
        output busy, done, ZHigh, ZLow, carry, div_zero
    );
endinterface

// File: rtl/seq_alu.sv
// seq_alu: registered multi-cycle ALU. Single-cycle ops finish on the start
// edge; MUL is iterative Booth, DIV is iterative non-restoring plus a fix-up.
// Build option: define SEQ_ALU_MUL_RADIX4_EN for radix-4 Booth (W/2 steps).
module seq_alu #(
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 16
) (
    input  logic        clock,
    input  logic        clear_n,
    seq_alu_if.slave    bus
);
    localparam int W  = DATA_WIDTH;
    localparam int SW = $clog2(W);
`ifdef SEQ_ALU_MUL_RADIX4_EN
    localparam int MSTEPS = W / 2;
`else
    localparam int MSTEPS = W;
`endif

    typedef enum logic [1:0] {IDLE, MUL, DIV, DIV_FIX} state_t;

    state_t          state_q;
    logic [SW-1:0]   cnt_q;
    logic            done_q, carry_q, dz_q;
    logic [W-1:0]    zhi_q, zlo_q;
    // Booth state: {hi, lo, q-1}; hi carries two guard bits for the 2M multiple
    logic [W+1:0]    mhi_q;
    logic [W-1:0]    mlo_q, mcand_q;
    logic            mq_q;
    // Divider state: signed partial remainder, quotient/dividend shifter, |divisor|
    logic [W+1:0]    rem_q;
    logic [W-1:0]    quo_q, dvs_q;
    logic            negq_q, negr_q;

    logic [SW-1:0]   amt;
    logic [2*W-1:0]  rolx, rorx;
    logic [W-1:0]    a_mag, b_mag;
    logic [W-1:0]    alu_hi, alu_lo;
    logic            alu_c, alu_dz;
    logic [W:0]      sum;

    assign amt   = bus.B[SW-1:0];
    assign rolx  = {bus.A, bus.A} << amt;
    assign rorx  = {bus.A, bus.A} >> amt;
    assign a_mag = bus.A[W-1] ? -bus.A : bus.A;
    assign b_mag = bus.B[W-1] ? -bus.B : bus.B;

    // Single-cycle result, including divide-by-zero and invalid opcodes
    always_comb begin
        alu_hi = '0;
        alu_lo = '0;
        alu_c  = 1'b0;
        alu_dz = 1'b0;
        sum    = '0;
        case (bus.ALU_Sel)
            SEL_WIDTH'(1):  alu_lo = bus.A & bus.B;
            SEL_WIDTH'(2):  alu_lo = bus.A | bus.B;
            SEL_WIDTH'(3):  alu_lo = ~bus.B;
            SEL_WIDTH'(4):  alu_lo = bus.A ^ bus.B;
            SEL_WIDTH'(5):  alu_lo = ~(bus.A | bus.B);
            SEL_WIDTH'(6):  alu_lo = -bus.B;
            SEL_WIDTH'(7):  alu_lo = rolx[2*W-1:W];
            SEL_WIDTH'(8):  alu_lo = rorx[W-1:0];
            SEL_WIDTH'(9):  alu_lo = bus.A << amt;
            SEL_WIDTH'(10): alu_lo = bus.A >> amt;
            SEL_WIDTH'(11): alu_lo = $signed(bus.A) >>> amt;
            SEL_WIDTH'(12): begin
                sum    = {1'b0, bus.A} + {1'b0, bus.B};
                alu_lo = sum[W-1:0];
                alu_c  = sum[W];
            end
            SEL_WIDTH'(13): begin
                sum    = {1'b0, bus.A} + {1'b0, ~bus.B} + (W+1)'(1);
                alu_lo = sum[W-1:0];
                alu_c  = sum[W];
            end
            SEL_WIDTH'(15): begin
                // only reaches the output path when the divisor is zero
                alu_lo = '1;
                alu_hi = bus.A;
                alu_dz = 1'b1;
            end
            default: ;
        endcase
    end

    logic [W+1:0] m_hi, m_ext, m_add, mul_hi_d;
    logic [W-1:0] m_lo, mul_lo_d;
    logic         m_q, mul_q_d;

    // One Booth step; from IDLE the first step is applied to the port operands
    always_comb begin
        m_hi  = (state_q == IDLE) ? '0 : mhi_q;
        m_lo  = (state_q == IDLE) ? bus.B : mlo_q;
        m_q   = (state_q == IDLE) ? 1'b0 : mq_q;
        m_ext = (state_q == IDLE) ? {{2{bus.A[W-1]}}, bus.A} : {{2{mcand_q[W-1]}}, mcand_q};
`ifdef SEQ_ALU_MUL_RADIX4_EN
        case ({m_lo[1:0], m_q})
            3'b001, 3'b010: m_add = m_hi + m_ext;
            3'b011:         m_add = m_hi + (m_ext << 1);
            3'b100:         m_add = m_hi - (m_ext << 1);
            3'b101, 3'b110: m_add = m_hi - m_ext;
            default:        m_add = m_hi;
        endcase
        mul_q_d  = m_lo[1];
        mul_lo_d = {m_add[1:0], m_lo[W-1:2]};
        mul_hi_d = {{2{m_add[W+1]}}, m_add[W+1:2]};
`else
        case ({m_lo[0], m_q})
            2'b01:   m_add = m_hi + m_ext;
            2'b10:   m_add = m_hi - m_ext;
            default: m_add = m_hi;
        endcase
        mul_q_d  = m_lo[0];
        mul_lo_d = {m_add[0], m_lo[W-1:1]};
        mul_hi_d = {m_add[W+1], m_add[W+1:1]};
`endif
    end

    logic [W+1:0] d_r, d_sh, d_div, rem_d, r_fix;
    logic [W-1:0] d_q, quo_d, r_mag;

    // One non-restoring step on magnitudes, plus the final remainder correction
    always_comb begin
        d_r   = (state_q == IDLE) ? '0 : rem_q;
        d_q   = (state_q == IDLE) ? a_mag : quo_q;
        d_div = (state_q == IDLE) ? {2'b00, b_mag} : {2'b00, dvs_q};
        d_sh  = {d_r[W:0], d_q[W-1]};
        rem_d = d_r[W+1] ? d_sh + d_div : d_sh - d_div;
        quo_d = {d_q[W-2:0], ~rem_d[W+1]};
        r_fix = rem_q[W+1] ? rem_q + {2'b00, dvs_q} : rem_q;
        r_mag = r_fix[W-1:0];
    end

    assign bus.busy     = (state_q != IDLE);
    assign bus.done     = done_q;
    assign bus.ZHigh    = zhi_q;
    assign bus.ZLow     = zlo_q;
    assign bus.carry    = carry_q;
    assign bus.div_zero = dz_q;

    // Control FSM with registered result/flag outputs
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            carry_q <= 1'b0;
            dz_q    <= 1'b0;
            zhi_q   <= '0;
            zlo_q   <= '0;
            mhi_q   <= '0;
            mlo_q   <= '0;
            mq_q    <= 1'b0;
            mcand_q <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    if (bus.ALU_Sel == SEL_WIDTH'(14)) begin
                        state_q <= MUL;
                        cnt_q   <= SW'(1);
                        mcand_q <= bus.A;
                        mhi_q   <= mul_hi_d;
                        mlo_q   <= mul_lo_d;
                        mq_q    <= mul_q_d;
                    end else if (bus.ALU_Sel == SEL_WIDTH'(15) && bus.B != '0) begin
                        state_q <= DIV;
                        cnt_q   <= SW'(1);
                        dvs_q   <= b_mag;
                        negq_q  <= bus.A[W-1] ^ bus.B[W-1];
                        negr_q  <= bus.A[W-1];
                        rem_q   <= rem_d;
                        quo_q   <= quo_d;
                    end else begin
                        zhi_q   <= alu_hi;
                        zlo_q   <= alu_lo;
                        carry_q <= alu_c;
                        dz_q    <= alu_dz;
                        done_q  <= 1'b1;
                    end
                end
                MUL: begin
                    mhi_q <= mul_hi_d;
                    mlo_q <= mul_lo_d;
                    mq_q  <= mul_q_d;
                    if (cnt_q == SW'(MSTEPS - 1)) begin
                        state_q <= IDLE;
                        zhi_q   <= mul_hi_d[W-1:0];
                        zlo_q   <= mul_lo_d;
                        carry_q <= 1'b0;
                        dz_q    <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + SW'(1);
                    end
                end
                DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == SW'(W - 1)) state_q <= DIV_FIX;
                    else                     cnt_q   <= cnt_q + SW'(1);
                end
                DIV_FIX: begin
                    state_q <= IDLE;
                    zlo_q   <= negq_q ? -quo_q : quo_q;
                    zhi_q   <= negr_q ? -r_mag : r_mag;
                    carry_q <= 1'b0;
                    dz_q    <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu latency, results and flags.
module tb_seq_alu;
    localparam int W = 32;
`ifdef SEQ_ALU_MUL_RADIX4_EN
    localparam int MUL_LAT = W / 2;
`else
    localparam int MUL_LAT = W;
`endif

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    seq_alu_if #(.DATA_WIDTH(W), .SEL_WIDTH(16)) bus ();
    seq_alu #(.DATA_WIDTH(W), .SEL_WIDTH(16)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one request for the start edge; returns #1 after that edge
    task automatic launch(input logic [15:0] sel, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clock);
        bus.start = 1'b1; bus.ALU_Sel = sel; bus.A = a; bus.B = b;
        @(posedge clock); #1;
        bus.start = 1'b0;
    endtask

    // Latency = number of edges from the start edge (inclusive) to done
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (bus.done !== 1'b1 && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [15:0] sel, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int exp_lat, input logic [63:0] exp_z,
                         input logic exp_c, input logic exp_dz);
        int lat;
        launch(sel, a, b);
        wait_done(1, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_z"}, {bus.ZHigh, bus.ZLow}, exp_z);
        chk({tag, "_flags"}, {62'd0, bus.carry, bus.div_zero}, {62'd0, exp_c, exp_dz});
        chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    endtask

    initial begin
        int lat;
        logic saw;
        bus.start = 1'b0; bus.ALU_Sel = '0; bus.A = '0; bus.B = '0;
        #3;
        chk("reset_out", {bus.busy, bus.done, bus.carry, bus.div_zero, bus.ZHigh, bus.ZLow}, '0);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;

        // ADD with carry, then done must be a single pulse
        do_op("add_carry", 16'd12, 32'hFFFF_FFFF, 32'h1, 1, 64'h0, 1'b1, 1'b0);
        @(posedge clock); #1;
        chk("done_pulse", {63'd0, bus.done}, 64'd0);

        // MUL -3*7 with an ignored ADD start at cycle 5
        launch(16'd14, -32'sd3, 32'd7);
        repeat (4) begin @(posedge clock); #1; end
        bus.start = 1'b1; bus.ALU_Sel = 16'd12; bus.A = 32'd1; bus.B = 32'd1;
        @(posedge clock); #1;
        bus.start = 1'b0;
        chk("mul_busy", {62'd0, bus.busy, bus.done}, 64'd2);
        chk("mul_hold", {bus.ZHigh, bus.ZLow}, 64'h0);
        wait_done(6, lat);
        chk("mul_lat", 64'(lat), 64'(MUL_LAT));
        chk("mul_z", {bus.ZHigh, bus.ZLow}, 64'hFFFF_FFFF_FFFF_FFEB);
        chk("mul_carry", {63'd0, bus.carry}, 64'd0);
        @(posedge clock); #1;
        chk("mul_after", {bus.ZHigh, bus.ZLow}, 64'hFFFF_FFFF_FFFF_FFEB);
        do_op("mul_min", 16'd14, 32'h8000_0000, 32'h8000_0000, MUL_LAT, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
        do_op("mul_pos", 16'd14, 32'd12345, -32'sd1, MUL_LAT, 64'hFFFF_FFFF_FFFF_CFC7, 1'b0, 1'b0);

        // Signed divide, sign rules and overflow
        do_op("div_neg", 16'd15, -32'sd17, 32'd5, W + 1, 64'hFFFF_FFFE_FFFF_FFFD, 1'b0, 1'b0);
        do_op("div_ovf", 16'd15, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 64'h0000_0000_8000_0000, 1'b0, 1'b0);
        do_op("div_pos", 16'd15, 32'd100, 32'd7, W + 1, 64'h0000_0002_0000_000E, 1'b0, 1'b0);
        do_op("div_nd", 16'd15, 32'd7, -32'sd2, W + 1, 64'h0000_0001_FFFF_FFFD, 1'b0, 1'b0);

        // Divide by zero, then back-to-back ADD clears div_zero
        do_op("div_zero", 16'd15, 32'd9, 32'd0, 1, 64'h0000_0009_FFFF_FFFF, 1'b0, 1'b1);
        do_op("add_b2b", 16'd12, 32'd1, 32'd1, 1, 64'h2, 1'b0, 1'b0);

        // Shifts, rotates, logic, invalid opcodes
        do_op("shra", 16'd11, 32'h8000_0000, 32'd4, 1, 64'hF800_0000, 1'b0, 1'b0);
        do_op("rol36", 16'd7, 32'h8000_0001, 32'd36, 1, 64'h18, 1'b0, 1'b0);
        do_op("shr31", 16'd10, 32'h8000_0000, 32'd31, 1, 64'h1, 1'b0, 1'b0);
        do_op("ror1", 16'd8, 32'h1, 32'd1, 1, 64'h8000_0000, 1'b0, 1'b0);
        do_op("shl", 16'd9, 32'h0000_00F1, 32'd8, 1, 64'h0000_F100, 1'b0, 1'b0);
        do_op("sub_neg", 16'd13, 32'd5, 32'd7, 1, 64'hFFFF_FFFE, 1'b0, 1'b0);
        do_op("sub_pos", 16'd13, 32'd7, 32'd5, 1, 64'h2, 1'b1, 1'b0);
        do_op("neg", 16'd6, 32'd0, 32'd1, 1, 64'hFFFF_FFFF, 1'b0, 1'b0);
        do_op("op0", 16'd0, 32'h1234_5678, 32'h9, 1, 64'h0, 1'b0, 1'b0);
        do_op("xor", 16'd4, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 64'h0FF0_0FF0, 1'b0, 1'b0);
        do_op("op16", 16'd16, 32'h1234_5678, 32'h9, 1, 64'h0, 1'b0, 1'b0);
        do_op("and", 16'd1, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 64'hF000_F000, 1'b0, 1'b0);
        do_op("add_ff", 16'd12, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE, 1'b1, 1'b0);

        // Reset in the middle of a MUL aborts it
        launch(16'd14, 32'd3, 32'd4);
        repeat (8) begin @(posedge clock); #1; end
        @(negedge clock);
        clear_n = 1'b0;
        #1;
        chk("rst_mid", {bus.busy, bus.done, bus.carry, bus.div_zero, bus.ZHigh, bus.ZLow}, '0);
        repeat (2) @(negedge clock);
        clear_n = 1'b1;
        saw = 1'b0;
        repeat (W + 4) begin
            @(posedge clock); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw = 1'b1;
        end
        chk("rst_no_done", {63'd0, saw}, 64'd0);
        do_op("add_post", 16'd12, 32'd2, 32'd3, 1, 64'h5, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Multi-cycle, registered successor to the datapath ALU, parametrised in DATA_WIDTH.
- Same opcode map on ALU_Sel (1..15). Single-cycle ops finish in one clock; signed multiply (iterative Booth) and signed divide (iterative non-restoring) run over several clocks.
- Sits between the register file/Y register and the Z register; the control unit drives the start/busy/done handshake and stalls while busy.

Parameters:
- DATA_WIDTH, 32, operand width W; even, >= 4.
- SEL_WIDTH, 16, opcode bus width.

Ports:
- clock  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only when busy=0.
- ALU_Sel  in  SEL_WIDTH  opcode, latched with start.
- A  in  DATA_WIDTH  operand A, latched with start.
- B  in  DATA_WIDTH  operand B / shift amount, latched with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- ZHigh  out  DATA_WIDTH  high result word (held until next done).
- ZLow  out  DATA_WIDTH  low result word (held until next done).
- carry  out  1  carry-out of add/sub; 0 otherwise.
- div_zero  out  1  set with done when divisor was 0.

Behaviour:
- Reset: clear_n low asynchronously forces state=IDLE, busy=0, done=0, ZHigh=ZLow=0, carry=0, div_zero=0. Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, MUL, DIV, DIV_FIX.
- IDLE: start=1 latches A, B and ALU_Sel.
  - Ops 1-13, invalid codes and divide-by-zero: result computed and registered on that edge; done=1 next cycle; latency 1.
  - Op 14: go to MUL, busy=1.
  - Op 15 with B!=0: go to DIV, busy=1.
- MUL: radix-2 Booth, one step per clock, W steps, then IDLE with done=1. Latency W cycles from the start edge.
- DIV: W non-restoring steps, then DIV_FIX (remainder correction and sign fix), then IDLE with done=1. Latency W+1.
- start while busy=1 is ignored; operands are not re-latched.
- done is a registered single-cycle pulse.
  - Back-to-back: start asserted in the same cycle as done is accepted.
  - busy is 0 whenever done is 1.
- Outputs update only on the done edge. carry and div_zero are rewritten on every done.
- Width rules: unless stated, ZHigh=0 and ZLow carries the W-bit result.
  - 1 AND, 2 OR, 4 XOR, 5 NOR: bitwise A op B.
  - 3 NOT: ~B.
  - 6 NEG: -B mod 2^W.
  - 12 ADD: A+B mod 2^W; carry = bit W of the sum.
  - 13 SUB: A+~B+1; carry = carry-out.
  - 7 ROL, 8 ROR: rotate A by B[log2W-1:0].
  - 9 SHL, 10 SHR: logical shift of A by B[log2W-1:0].
  - 11 SHRA: arithmetic shift of A by B[log2W-1:0].
  - 14 MUL: signed A*B; {ZHigh,ZLow} = 2W-bit product.
  - 15 DIV: signed, truncates toward zero. ZLow = quotient; ZHigh = remainder, with the sign of the dividend.
  - DIV overflow: -2^(W-1) / -1 gives ZLow = -2^(W-1), ZHigh = 0.
  - DIV by zero: ZLow = all ones, ZHigh = A, div_zero = 1, latency 1.
  - Opcode 0 or 16..2^SEL_WIDTH-1: ZHigh = ZLow = 0, latency 1.

Optional Feature:
- SEQ_ALU_MUL_RADIX4_EN defined: MUL uses radix-4 Booth, two bits per clock. MUL latency = W/2; results are bit-identical to radix-2.
- Undefined: radix-2 Booth, latency W.
- All other ops are unaffected either way.

Test Plan:
1. ADD, A=0xFFFFFFFF, B=0x00000001 -> done exactly 1 cycle after start; ZLow=0x00000000, ZHigh=0, carry=1.
2. MUL, A=-3, B=7 -> ZHigh=0xFFFFFFFF, ZLow=0xFFFFFFEB, done exactly 32 cycles after start (16 with SEQ_ALU_MUL_RADIX4_EN). A start at cycle 5 with ADD is ignored and results are unchanged.
3. DIV, A=-17, B=5 -> ZLow=0xFFFFFFFD (-3), ZHigh=0xFFFFFFFE (-2), done 33 cycles after start. Then DIV 0x80000000 / 0xFFFFFFFF -> ZLow=0x80000000, ZHigh=0.
4. DIV, A=9, B=0 -> done after 1 cycle; div_zero=1, ZLow=0xFFFFFFFF, ZHigh=0x00000009. A following ADD 1+1 gives ZLow=2, div_zero=0.
5. SHRA 0x80000000 by 4 -> 0xF8000000. ROL 0x80000001 by B=36 (amount 4) -> 0x00000018. SHR 0x80000000 by 31 -> 0x00000001. Opcode 0 -> ZLow=ZHigh=0.
6. Start MUL, pull clear_n low at cycle 10 -> busy, done, ZHigh, ZLow and carry are 0 immediately and no done follows. After release, ADD 2+3 -> ZLow=5, latency 1.
